// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with 16x oversampling, mid-bit sampling and sticky rdy/overrun flags.
// Define UART_RX_PARITY_EN to insert and check one even-parity bit before the stop bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity over data plus received parity bit; 1 means mismatch.
  function automatic logic parity_check(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t          state_r;
  logic [1:0]      rx_sync_r;
  logic [TW-1:0]   tick_r;
  logic [2:0]      bitpos_r;
  logic [7:0]      shift_r;
  logic            rx_s;
  logic            tick_wrap_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_r;
`endif

  assign rx_s        = rx_sync_r[1];
  assign tick_wrap_s = (tick_r == TICK_LAST);

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end

  // Receive state machine with registered byte, status flags and busy indication.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_r     <= '0;
      bitpos_r   <= 3'd0;
      shift_r    <= 8'h00;
      dout       <= 8'h00;
      rdy        <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r  <= 1'b0;
`endif
    end else begin
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (clken) begin
        case (state_r)
          IDLE: begin
            if (!rx_s) begin
              state_r <= START;
              tick_r  <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            // A low level at mid start bit confirms the frame; otherwise it was a glitch.
            if (tick_r == TICK_HALF) begin
              tick_r <= '0;
              if (!rx_s) begin
                state_r  <= DATA;
                bitpos_r <= 3'd0;
              end else begin
                state_r <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_r <= tick_r + 1'b1;
            end
          end
          DATA: begin
            if (tick_wrap_s) begin
              tick_r            <= '0;
              shift_r[bitpos_r] <= rx_s;
              if (bitpos_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end else begin
                bitpos_r <= bitpos_r + 3'd1;
              end
            end else begin
              tick_r <= tick_r + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_wrap_s) begin
              tick_r    <= '0;
              par_bit_r <= rx_s;
              state_r   <= STOP;
            end else begin
              tick_r <= tick_r + 1'b1;
            end
          end
`endif
          STOP: begin
            // Leave at mid-stop so the next start edge is caught on time.
            if (tick_wrap_s) begin
              tick_r  <= '0;
              state_r <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                dout      <= shift_r;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= parity_check(shift_r, par_bit_r);
`else
                parity_err <= 1'b0;
`endif
                if (rdy && !rdy_clr) begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_r <= tick_r + 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            tick_r  <= '0;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; clken pulses every 4 clocks, one bit = 64 clocks.
module tb_uart_rx;

  logic        clk_50m = 1'b0;
  logic        rst     = 1'b1;
  logic        rx      = 1'b1;
  logic        rdy_clr = 1'b0;
  logic        clken;
  logic [7:0]  dout;
  logic        rdy;
  logic        overrun;
  logic        frame_err;
  logic        parity_err;
  logic        rx_busy;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx         (rx),
    .clken      (clken),
    .rdy_clr    (rdy_clr),
    .dout       (dout),
    .rdy        (rdy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  assign clken = (cyc[1:0] == 2'd3);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic gap();
    repeat (16) @(negedge clk_50m);
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  // Start bit lands just before a clken edge, so tick 0 is the following clken (4 clocks later)
  // and the stop sample happens on the rising edge 64*STOP_IDX+36 clocks after the start.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int abort_at, input logic clr_at_stop, input logic rdy_before);
    logic [10:0] bits;
    int          s;
    bits[0]   = 1'b0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    bits[9]  = par;
    bits[10] = stop;
`else
    bits[9]  = stop;
    bits[10] = par | 1'b1;
`endif
    s = 64 * STOP_IDX + 36;
    @(negedge clk_50m);
    while (cyc[1:0] != 2'd3) @(negedge clk_50m);
    for (int k = 0; k <= s; k++) begin
      if (k > 0) @(negedge clk_50m);
      if (k % 64 == 0) rx = bits[k / 64];
      if (k == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        return;
      end
    end
    check_val("rdy_before_stop", {31'd0, rdy}, {31'd0, rdy_before});
    check_val("busy_before_stop", {31'd0, rx_busy}, 32'd1);
    if (clr_at_stop) rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    rx      = 1'b1;
    check_val("busy_after_stop", {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_50m);
    check_val("rst_dout", {24'd0, dout}, 32'h00);
    check_val("rst_rdy", {31'd0, rdy}, 32'd0);
    check_val("rst_overrun", {31'd0, overrun}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check_val("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    gap();

    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_val("a5_dout", {24'd0, dout}, 32'hA5);
    check_val("a5_rdy", {31'd0, rdy}, 32'd1);
    check_val("a5_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("a5_parity_err", {31'd0, parity_err}, 32'd0);
    check_val("a5_overrun", {31'd0, overrun}, 32'd0);
    pulse_clr();
    check_val("a5_clr_rdy", {31'd0, rdy}, 32'd0);
    gap();

    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_val("3c_dout", {24'd0, dout}, 32'h3C);
    check_val("3c_overrun", {31'd0, overrun}, 32'd0);
    gap();
    send_frame(8'hC3, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    check_val("c3_dout", {24'd0, dout}, 32'hC3);
    check_val("c3_rdy", {31'd0, rdy}, 32'd1);
    check_val("c3_overrun", {31'd0, overrun}, 32'd1);
    pulse_clr();
    check_val("ovr_clr_rdy", {31'd0, rdy}, 32'd0);
    check_val("ovr_clr_overrun", {31'd0, overrun}, 32'd0);
    gap();

    send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    check_val("55_frame_err", {31'd0, frame_err}, 32'd1);
    check_val("55_rdy", {31'd0, rdy}, 32'd0);
    check_val("55_dout", {24'd0, dout}, 32'hC3);
    gap();
    send_frame(8'h01, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    check_val("01_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("01_dout", {24'd0, dout}, 32'h01);
    check_val("01_rdy", {31'd0, rdy}, 32'd1);
    gap();

    // 5-tick (20-clock) low glitch: start check at tick 8 must reject it.
    @(negedge clk_50m);
    while (cyc[1:0] != 2'd3) @(negedge clk_50m);
    rx = 1'b0;
    repeat (20) @(negedge clk_50m);
    rx = 1'b1;
    repeat (16) @(negedge clk_50m);
    check_val("glitch_busy_t8", {31'd0, rx_busy}, 32'd1);
    @(negedge clk_50m);
    check_val("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
    check_val("glitch_rdy", {31'd0, rdy}, 32'd1);
    check_val("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("glitch_dout", {24'd0, dout}, 32'h01);
    check_val("glitch_overrun", {31'd0, overrun}, 32'd0);
    gap();

    // Reset at tick 80 of a frame: 4 + 4*80 = 324 clocks after the start bit.
    send_frame(8'hFF, 1'b0, 1'b1, 324, 1'b0, 1'b1);
    #1;
    check_val("abort_dout", {24'd0, dout}, 32'h00);
    check_val("abort_rdy", {31'd0, rdy}, 32'd0);
    check_val("abort_overrun", {31'd0, overrun}, 32'd0);
    check_val("abort_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("abort_parity_err", {31'd0, parity_err}, 32'd0);
    check_val("abort_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk_50m);
    rst = 1'b0;
    gap();
    send_frame(8'hFF, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_val("ff_dout", {24'd0, dout}, 32'hFF);
    check_val("ff_rdy", {31'd0, rdy}, 32'd1);
    check_val("ff_frame_err", {31'd0, frame_err}, 32'd0);
    gap();

    // rdy_clr coinciding with the stop sample: completion wins, no overrun.
    send_frame(8'h81, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    check_val("81_dout", {24'd0, dout}, 32'h81);
    check_val("81_rdy", {31'd0, rdy}, 32'd1);
    check_val("81_overrun", {31'd0, overrun}, 32'd0);

`ifdef UART_RX_PARITY_EN
    pulse_clr();
    gap();
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    check_val("07p1_parity_err", {31'd0, parity_err}, 32'd0);
    check_val("07p1_dout", {24'd0, dout}, 32'h07);
    pulse_clr();
    gap();
    send_frame(8'h07, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    check_val("07p0_parity_err", {31'd0, parity_err}, 32'd1);
    check_val("07p0_rdy", {31'd0, rdy}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
